// File: rtl/pq_pkg.sv
// Shared types and constants for the sorted-array priority queue.
// Entry layout is width-parametrised through a macro so each module can size it.
`ifndef PQ_PKG_SV
`define PQ_PKG_SV

`define PQ_ENTRY_T(iw, pw) struct packed { logic [(iw)-1:0] id; logic [(pw)-1:0] prio; }

package pq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DROP_SRCH = 2'd1,
    ST_DROP_CMPT = 2'd2
  } pq_arr_state_e;

  localparam int PQ_EMPTY_ID = 0;

endpackage

`endif

// File: rtl/pq_insert_pos.sv
// Insert position for a sorted entry array: count of valid entries with prio >= new prio,
// plus a one-hot marker of that slot (all-zero when the slot is past the end).
module pq_insert_pos #(
  parameter  int DEPTH = 8,
  parameter  int PW    = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic [DEPTH-1:0][PW-1:0] i_prio,
  input  logic [DEPTH-1:0]         i_vld,
  input  logic [PW-1:0]            i_push_prio,
  output logic [CW-1:0]            o_pos,
  output logic [DEPTH-1:0]         o_onehot
);

  logic [DEPTH-1:0] w_ge;

  always_comb begin
    o_pos = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_ge[i] = i_vld[i] & (i_prio[i] >= i_push_prio);
      o_pos   = o_pos + CW'(w_ge[i]);
    end
  end

  // w_ge is a thermometer because the array is sorted; the slot is its first zero.
  always_comb begin
    o_onehot[0] = ~w_ge[0];
    for (int i = 1; i < DEPTH; i++) begin
      o_onehot[i] = ~w_ge[i] & w_ge[i-1];
    end
  end

endmodule

// File: rtl/pq_sorted_array.sv
// Sorted-array priority queue: push / pop / push+pop bypass / drop-by-id / head peek.
//   state        | meaning
//   ST_IDLE      | accepts push, pop, drop; peek valid when non-empty
//   ST_DROP_SRCH | registers first match of the latched drop id
//   ST_DROP_CMPT | removes the match (if any), pulses drop_vld_o
module pq_sorted_array
  import pq_pkg::*;
#(
  parameter  int DEPTH = 8,
  parameter  int IW    = 4,
  parameter  int PW    = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [IW-1:0] push_id_i,
  input  logic [PW-1:0] push_prio_i,
  output logic          push_rdy_o,
  input  logic          pop_i,
  output logic          pop_rdy_o,
  output logic          pop_vld_o,
  output logic [IW-1:0] pop_id_o,
  output logic [PW-1:0] pop_prio_o,
  input  logic          drop_i,
  input  logic [IW-1:0] drop_id_i,
  output logic          drop_rdy_o,
  output logic          drop_vld_o,
  output logic          drop_hit_o,
  output logic          peek_vld_o,
  output logic [IW-1:0] peek_id_o,
  output logic [PW-1:0] peek_prio_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o,
  output logic          err_o
);

  typedef `PQ_ENTRY_T(IW, PW) pq_entry_t;

  localparam logic [IW-1:0] EMPTY_ID = IW'(PQ_EMPTY_ID);

  pq_arr_state_e            r_state, w_state_nxt;
  pq_entry_t [DEPTH-1:0]    r_arr, w_shift, w_base, w_base_dn, w_ins_arr, w_drop_arr;
  pq_entry_t                r_pop_ent, w_push_ent;
  logic [CW-1:0]            r_cnt, w_cnt_nxt, w_pos;
  logic [DEPTH-1:0]         r_match, w_match, w_vld, w_vld_sh, w_base_vld, w_onehot;
  logic [DEPTH-1:0][PW-1:0] w_base_prio;
  logic [IW-1:0]            r_drop_id;
  logic                     r_pop_vld, r_err;
  logic                     w_full, w_empty, w_push_acc, w_pop_acc, w_drop_acc;
  logic                     w_push_ok, w_bypass, w_pop_head, w_ins, w_err;

  assign w_full     = (r_cnt == CW'(DEPTH));
  assign w_empty    = (r_cnt == '0);
  assign w_push_ent = {push_id_i, push_prio_i};
  assign w_shift    = r_arr >> (IW + PW);

  assign w_push_acc = push_i & push_rdy_o;
  assign w_pop_acc  = pop_i & pop_rdy_o;
  assign w_drop_acc = drop_i & drop_rdy_o;
  assign w_push_ok  = w_push_acc & (push_id_i != EMPTY_ID);
  assign w_bypass   = w_pop_acc & w_push_ok & (w_empty | (push_prio_i > r_arr[0].prio));
  assign w_pop_head = w_pop_acc & ~w_empty & ~w_bypass;
  assign w_ins      = w_push_ok & ~w_bypass;
  assign w_err      = (w_push_acc & (push_id_i == EMPTY_ID)) | (w_pop_acc & w_empty & ~w_push_ok);

  // Push+pop inserts into the head-removed view so a full queue still has room.
  assign w_base     = w_pop_head ? w_shift : r_arr;
  assign w_base_vld = w_pop_head ? w_vld_sh : w_vld;
  assign w_base_dn  = w_base << (IW + PW);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_vld[i]       = (CW'(i) < r_cnt);
      w_vld_sh[i]    = (CW'(i + 1) < r_cnt);
      w_base_prio[i] = w_base[i].prio;
    end
  end

  pq_insert_pos #(.DEPTH(DEPTH), .PW(PW)) u_insert_pos (
    .i_prio      (w_base_prio),
    .i_vld       (w_base_vld),
    .i_push_prio (push_prio_i),
    .o_pos       (w_pos),
    .o_onehot    (w_onehot)
  );

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_onehot[i])        w_ins_arr[i] = w_push_ent;
      else if (CW'(i) > w_pos) w_ins_arr[i] = w_base_dn[i];
      else                    w_ins_arr[i] = w_base[i];
    end
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_ins && !w_pop_head)      w_cnt_nxt = r_cnt + CW'(1);
    else if (w_pop_head && !w_ins) w_cnt_nxt = r_cnt - CW'(1);
  end

  // Lowest index wins, so duplicates lose only their highest-priority copy.
  always_comb begin
    logic found;
    found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_match[i] = w_vld[i] & (r_arr[i].id == r_drop_id) & (r_drop_id != EMPTY_ID) & ~found;
      found      = found | w_match[i];
    end
  end

  always_comb begin
    logic behind;
    behind = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      behind        = behind | r_match[i];
      w_drop_arr[i] = behind ? w_shift[i] : r_arr[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:      if (w_drop_acc) w_state_nxt = ST_DROP_SRCH;
      ST_DROP_SRCH: w_state_nxt = ST_DROP_CMPT;
      ST_DROP_CMPT: w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pop_rdy_o  = 1'b0;
    push_rdy_o = 1'b0;
    drop_rdy_o = 1'b0;
    peek_vld_o = 1'b0;
    drop_vld_o = 1'b0;
    drop_hit_o = 1'b0;
    case (r_state)
      ST_IDLE: begin
        pop_rdy_o  = 1'b1;
        push_rdy_o = ~w_full | pop_i;
        drop_rdy_o = ~push_i & ~pop_i;
        peek_vld_o = ~w_empty;
      end
      ST_DROP_CMPT: begin
        drop_vld_o = 1'b1;
        drop_hit_o = |r_match;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_arr     <= '0;
      r_cnt     <= '0;
      r_match   <= '0;
      r_drop_id <= '0;
      r_pop_vld <= 1'b0;
      r_pop_ent <= '0;
      r_err     <= 1'b0;
    end else begin
      r_pop_vld <= w_pop_head | w_bypass;
      r_pop_ent <= w_bypass ? w_push_ent : r_arr[0];
      r_err     <= w_err;
      case (r_state)
        ST_IDLE: begin
          if (w_pop_head || w_ins) r_arr <= w_ins ? w_ins_arr : w_shift;
          r_cnt <= w_cnt_nxt;
          if (w_drop_acc) r_drop_id <= drop_id_i;
        end
        ST_DROP_SRCH: r_match <= w_match;
        ST_DROP_CMPT: begin
          if (|r_match) begin
            r_arr <= w_drop_arr;
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign pop_vld_o   = r_pop_vld;
  assign pop_id_o    = r_pop_ent.id;
  assign pop_prio_o  = r_pop_ent.prio;
  assign peek_id_o   = r_arr[0].id;
  assign peek_prio_o = r_arr[0].prio;
  assign full_o      = w_full;
  assign empty_o     = w_empty;
  assign count_o     = r_cnt;
  assign err_o       = r_err;

endmodule

// File: tb/tb_pq_sorted_array.sv
// Bench for pq_sorted_array: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pq_sorted_array;

  localparam int DEPTH = 8;
  localparam int IW    = 4;
  localparam int PW    = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          push_i = 1'b0, pop_i = 1'b0, drop_i = 1'b0;
  logic [IW-1:0] push_id_i = '0, drop_id_i = '0;
  logic [PW-1:0] push_prio_i = '0;
  logic          push_rdy_o, pop_rdy_o, pop_vld_o, drop_rdy_o, drop_vld_o, drop_hit_o;
  logic          peek_vld_o, full_o, empty_o, err_o;
  logic [IW-1:0] pop_id_o, peek_id_o;
  logic [PW-1:0] pop_prio_o, peek_prio_o;
  logic [CW-1:0] count_o;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int id;
    int prio;
  } ent_t;

  ent_t q[$];
  int   m_phase = 0;
  int   m_drop_id = 0;
  bit   e_pop_vld = 1'b0;
  bit   e_err = 1'b0;
  ent_t e_pop;
  bit   m_full, m_empty, m_pu_acc, m_dr_acc, m_pok;
  ent_t m_pe;

  always #5 clk_i = ~clk_i;

  pq_sorted_array #(.DEPTH(DEPTH), .IW(IW), .PW(PW)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push_i),
    .push_id_i   (push_id_i),
    .push_prio_i (push_prio_i),
    .push_rdy_o  (push_rdy_o),
    .pop_i       (pop_i),
    .pop_rdy_o   (pop_rdy_o),
    .pop_vld_o   (pop_vld_o),
    .pop_id_o    (pop_id_o),
    .pop_prio_o  (pop_prio_o),
    .drop_i      (drop_i),
    .drop_id_i   (drop_id_i),
    .drop_rdy_o  (drop_rdy_o),
    .drop_vld_o  (drop_vld_o),
    .drop_hit_o  (drop_hit_o),
    .peek_vld_o  (peek_vld_o),
    .peek_id_o   (peek_id_o),
    .peek_prio_o (peek_prio_o),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .count_o     (count_o),
    .err_o       (err_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    n_chk++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // New entry goes behind every entry with prio >= its own.
  function automatic void m_insert(input ent_t e);
    int pos = 0;
    foreach (q[i]) if (q[i].prio >= e.prio) pos++;
    q.insert(pos, e);
  endfunction

  function automatic int m_find(input int id);
    for (int i = 0; i < q.size(); i++) if (id != 0 && q[i].id == id) return i;
    return -1;
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q.delete();
      m_phase   = 0;
      m_drop_id = 0;
      e_pop_vld = 1'b0;
      e_err     = 1'b0;
    end else begin
      e_pop_vld = 1'b0;
      e_err     = 1'b0;
      if (m_phase == 0) begin
        m_full   = (q.size() == DEPTH);
        m_empty  = (q.size() == 0);
        m_pu_acc = push_i && (!m_full || pop_i);
        m_dr_acc = drop_i && !push_i && !pop_i;
        m_pe     = '{int'(push_id_i), int'(push_prio_i)};
        if (m_pu_acc && m_pe.id == 0) e_err = 1'b1;
        m_pok = m_pu_acc && m_pe.id != 0;
        if (pop_i) begin
          if (m_pok && (m_empty || m_pe.prio > q[0].prio)) begin
            e_pop_vld = 1'b1;
            e_pop     = m_pe;
            m_pok     = 1'b0;
          end else if (!m_empty) begin
            e_pop_vld = 1'b1;
            e_pop     = q.pop_front();
          end else begin
            e_err = 1'b1;
          end
        end
        if (m_pok) m_insert(m_pe);
        if (m_dr_acc) begin
          m_drop_id = int'(drop_id_i);
          m_phase   = 1;
        end
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else begin
        if (m_find(m_drop_id) >= 0) q.delete(m_find(m_drop_id));
        m_phase = 0;
      end
    end
  end

  always @(negedge clk_i) begin
    if (rst_ni) begin
      chk("count", count_o, q.size());
      chk("empty", empty_o, q.size() == 0);
      chk("full", full_o, q.size() == DEPTH);
      chk("peek_vld", peek_vld_o, m_phase == 0 && q.size() > 0);
      chk("peek_id", peek_id_o, q.size() > 0 ? q[0].id : 0);
      chk("peek_prio", peek_prio_o, q.size() > 0 ? q[0].prio : 0);
      chk("pop_rdy", pop_rdy_o, m_phase == 0);
      chk("push_rdy", push_rdy_o, m_phase == 0 && (q.size() < DEPTH || pop_i));
      chk("drop_rdy", drop_rdy_o, m_phase == 0 && !push_i && !pop_i);
      chk("pop_vld", pop_vld_o, e_pop_vld);
      if (e_pop_vld) begin
        chk("pop_id", pop_id_o, e_pop.id);
        chk("pop_prio", pop_prio_o, e_pop.prio);
      end
      chk("err", err_o, e_err);
      chk("drop_vld", drop_vld_o, m_phase == 2);
      if (m_phase == 2) chk("drop_hit", drop_hit_o, m_find(m_drop_id) >= 0);
    end
  end

  task automatic idle_inputs();
    push_i = 1'b0; pop_i = 1'b0; drop_i = 1'b0;
    push_id_i = '0; push_prio_i = '0; drop_id_i = '0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk_i);
  endtask

  task automatic op(input bit pu, input int id, input int pr, input bit po,
                    input bit dr = 1'b0, input int did = 0);
    push_i = pu; push_id_i = IW'(id); push_prio_i = PW'(pr);
    pop_i = po; drop_i = dr; drop_id_i = IW'(did);
    step();
    idle_inputs();
  endtask

  task automatic pop_lit(input int id);
    op(1'b0, 0, 0, 1'b1);
    at_neg();
    chk("lit_pop_vld", pop_vld_o, 1);
    chk("lit_pop_id", pop_id_o, id);
    step();
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    at_neg();
    chk("lit_rst_empty", empty_o, 1);
    chk("lit_rst_count", count_o, 0);
    chk("lit_rst_peek", peek_vld_o, 0);
    step();

    op(1'b1, 3, 5, 1'b0); op(1'b1, 7, 9, 1'b0); op(1'b1, 2, 5, 1'b0);
    at_neg();
    chk("lit_peek7", peek_id_o, 7);
    chk("lit_cnt3", count_o, 3);
    step();
    pop_lit(7); pop_lit(3); pop_lit(2);
    at_neg();
    chk("lit_empty_after_pops", empty_o, 1);
    step();

    for (int i = 1; i <= DEPTH; i++) op(1'b1, i, 1, 1'b0);
    at_neg();
    chk("lit_full", full_o, 1);
    step();
    push_i = 1'b1; push_id_i = 4'd9; push_prio_i = 4'd15;
    #1 chk("lit_push_rdy_full", push_rdy_o, 0);
    step();
    idle_inputs();
    op(1'b1, 9, 15, 1'b1);
    at_neg();
    chk("lit_bypass_vld", pop_vld_o, 1);
    chk("lit_bypass_id", pop_id_o, 9);
    chk("lit_bypass_cnt", count_o, 8);
    step();
    op(1'b1, 10, 0, 1'b1);
    at_neg();
    chk("lit_fullpp_id", pop_id_o, 1);
    chk("lit_fullpp_cnt", count_o, 8);
    step();
    repeat (DEPTH) op(1'b0, 0, 0, 1'b1);

    op(1'b1, 4, 6, 1'b0); op(1'b1, 5, 2, 1'b0);
    op(1'b1, 6, 3, 1'b1);
    at_neg();
    chk("lit_pp_id", pop_id_o, 4);
    chk("lit_pp_peek", peek_id_o, 6);
    step();
    pop_lit(6); pop_lit(5);

    op(1'b1, 1, 4, 1'b0); op(1'b1, 2, 4, 1'b0); op(1'b1, 3, 4, 1'b0);
    op(1'b0, 0, 0, 1'b0, 1'b1, 2);
    at_neg();
    chk("lit_drop_early", drop_vld_o, 0);
    step();
    at_neg();
    chk("lit_drop_vld", drop_vld_o, 1);
    chk("lit_drop_hit", drop_hit_o, 1);
    step();
    at_neg();
    chk("lit_drop_cnt", count_o, 2);
    step();
    op(1'b0, 0, 0, 1'b0, 1'b1, 9);
    step();
    at_neg();
    chk("lit_miss_vld", drop_vld_o, 1);
    chk("lit_miss_hit", drop_hit_o, 0);
    step();
    at_neg();
    chk("lit_miss_cnt", count_o, 2);
    step();
    pop_lit(1); pop_lit(3);

    op(1'b0, 0, 0, 1'b1);
    at_neg();
    chk("lit_err_pop", err_o, 1);
    chk("lit_err_pop_vld", pop_vld_o, 0);
    step();
    op(1'b1, 0, 3, 1'b0);
    at_neg();
    chk("lit_err_push", err_o, 1);
    chk("lit_err_push_cnt", count_o, 0);
    step();

    op(1'b1, 5, 3, 1'b0); op(1'b1, 5, 7, 1'b0); op(1'b1, 6, 5, 1'b0);
    op(1'b0, 0, 0, 1'b0, 1'b1, 5);
    step(); step();
    at_neg();
    chk("lit_dup_peek", peek_id_o, 6);
    chk("lit_dup_cnt", count_o, 2);
    step();
    pop_lit(6);
    op(1'b0, 0, 0, 1'b1);
    at_neg();
    chk("lit_dup_prio", pop_prio_o, 3);
    step();

    op(1'b1, 1, 3, 1'b0); op(1'b1, 2, 4, 1'b0);
    op(1'b0, 0, 0, 1'b0, 1'b1, 1);
    step();
    rst_ni = 1'b0;
    #1 chk("lit_rst_mid_vld", drop_vld_o, 0);
    chk("lit_rst_mid_cnt", count_o, 0);
    step(); step();
    rst_ni = 1'b1;
    repeat (3) begin
      at_neg();
      chk("lit_rst_no_pulse", drop_vld_o, 0);
      step();
    end
    at_neg();
    chk("lit_rst_idle_empty", empty_o, 1);
    chk("lit_rst_idle_pop_rdy", pop_rdy_o, 1);
    chk("lit_rst_idle_drop_rdy", drop_rdy_o, 1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pq_sorted_array.md
Name: pq_sorted_array

Overview:
- Parametrised successor to the per-cell priority-queue FSM.
- Holds DEPTH {id, prio} entries in one register array, kept sorted (head = entry 0 = highest priority).
- Parallel compare logic replaces the chained per-cell handshakes.
- Supports push, pop, combined push+pop with bypass, drop-by-id, and a head peek. Sits between the interrupt/task source and the consumer of the priority queue.

Parameters:
DEPTH, 8, number of entries (>=2)
IW, 4, id width; id 0 is reserved as the empty marker
PW, 4, priority width; larger value = more urgent
CW, $clog2(DEPTH+1), occupancy counter width (derived, not overridable)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
push_i  in  1  push request
push_id_i  in  IW  id to insert
push_prio_i  in  PW  priority of pushed id
push_rdy_o  out  1  push accepted this cycle when push_i & push_rdy_o
pop_i  in  1  pop request
pop_rdy_o  out  1  pop accepted this cycle when pop_i & pop_rdy_o
pop_vld_o  out  1  one-cycle pulse, pop result valid
pop_id_o  out  IW  popped id
pop_prio_o  out  PW  popped priority
drop_i  in  1  remove entry by id
drop_id_i  in  IW  id to remove
drop_rdy_o  out  1  drop accepted
drop_vld_o  out  1  one-cycle pulse, drop finished
drop_hit_o  out  1  qualifies drop_vld_o: id was found and removed
peek_vld_o  out  1  queue non-empty and state IDLE
peek_id_o  out  IW  head id
peek_prio_o  out  PW  head priority
full_o  out  1  count == DEPTH
empty_o  out  1  count == 0
count_o  out  CW  occupancy
err_o  out  1  one-cycle pulse on illegal accepted request

Behaviour:
- Reset: all entries {0,0}; count 0; state IDLE. All pulses 0, empty_o=1, full_o=0, peek outputs 0, all rdy as per IDLE rules.
- Ordering: a new entry goes behind every entry with prio >= its own (FIFO among equal priorities). Insert position = number of valid entries with prio >= push_prio_i. Entries at and behind that position shift back by one.
- FSM states: IDLE, DROP_SRCH, DROP_CMPT.
- IDLE ready rules:
  - pop_rdy_o = 1.
  - push_rdy_o = ~full_o | pop_i.
  - drop_rdy_o = ~push_i & ~pop_i (drop has lowest precedence).
- Latency: accepted push/pop updates the array at the next edge. pop_vld_o with its data appears the cycle after acceptance. count_o and peek outputs reflect the update in that same cycle.
- Push alone: insert as above; count+1.
- Pop alone, non-empty: return the head; shift all entries forward; last entry becomes {0,0}; count-1.
- Pop on empty: accepted. pop_vld_o stays 0, err_o pulses, no state change.
- Push+pop same cycle, queue empty or push_prio_i > head prio (strict): bypass. Pop returns the pushed pair; array and count unchanged.
- Push+pop same cycle, otherwise: pop returns the head; pushed entry is inserted into the remaining array; count unchanged. Legal when full.
- Push with push_id_i == 0: accepted, discarded, err_o pulses. Any accompanying pop proceeds normally.
- Drop (IDLE -> DROP_SRCH):
  - drop_id_i is registered.
  - In DROP_SRCH, a one-hot first-match over valid entries is registered; go to DROP_CMPT.
  - In DROP_CMPT: on a match, entries behind it shift forward and count-1. drop_vld_o=1; drop_hit_o=match. Return to IDLE.
  - During both drop states all rdy outputs and peek_vld_o are 0.
  - Drop of id 0, or an absent id: drop_vld_o=1, drop_hit_o=0, array unchanged.
  - Duplicates: only the highest-priority match is removed.
- Total drop latency: drop_vld_o 2 cycles after acceptance.
- Counter saturation cannot occur: push alone is not ready when full.
- Reset mid-operation (e.g. in DROP_CMPT): everything returns to reset values immediately. No pulse is emitted afterwards.

Decomposition:
- Package pq_pkg:
  - typedef pq_entry_t {logic [IW-1:0] id; logic [PW-1:0] prio;} (parametrised through a macro or the module-level struct).
  - State enum pq_arr_state_e.
  - Constant PQ_EMPTY_ID = 0.
- One sub-module, pq_insert_pos: combinational; computes the insert index and one-hot shift mask from the entry priorities, valid vector and push_prio_i. Reused for the push+pop path with a head-removed view.

Test Plan:
- Reset, then push (3,p5), (7,p9), (2,p5) -> peek_id_o=7. Pops return 7,3,2 in that order; count_o 3->0; empty_o=1 after the third pop.
- DEPTH=8: fill with ids 1..8, prio 1. full_o=1, push_rdy_o=0 with push alone. Then push (9,p15) + pop in the same cycle -> bypass: pop_id_o=9, count_o stays 8.
- Queue {(4,p6),(5,p2)}; push (6,p3) + pop -> pop_id_o=4. Then peek_id_o=6, order 6,5.
- Queue {1,2,3} all prio 4; drop id 2 -> drop_vld_o 2 cycles after acceptance, drop_hit_o=1, pops give 1,3. Drop id 9 -> drop_hit_o=0, count unchanged at 2.
- Empty queue: pop -> err_o=1, pop_vld_o=0. Push id 0 -> err_o=1, count_o=0.
- Assert rst_ni low during DROP_CMPT -> drop_vld_o never pulses; empty_o=1 and state IDLE after release.
